// File: rtl/game_pkg.sv
// Shared game types: FSM states and grid geometry.
// Imported by the grid frame controller and its bench.
package game_pkg;

  localparam int NTILES = 16;
  localparam int IDX_W  = $clog2(NTILES);

  typedef enum logic [1:0] {
    ST_WELCOME = 2'd0,
    ST_ARM     = 2'd1,
    ST_PLAY    = 2'd2
  } state_t;

endpackage

// File: rtl/grid_frame_controller_if.sv
// Bundle between grid sources, the frame controller
// and the renderer; master = environment side.
interface grid_frame_controller_if #(
  parameter int NT        = 16,
  parameter int TILE_BITS = 4,
  parameter int AGE_W     = 3,
  parameter int IDX_W     = 4
);

  logic                    vsync;
  logic                    any_button;
  logic [NT*TILE_BITS-1:0] welcome_grid;
  logic [NT*TILE_BITS-1:0] logic_grid;
  logic                    added_valid;
  logic [IDX_W-1:0]        added_index;
  logic [NT*TILE_BITS-1:0] frame_grid;
  logic [NT-1:0]           new_tiles;
  logic [NT*AGE_W-1:0]     tile_age;
  logic                    moves_enable;
  logic                    show_welcome;
  logic                    frame_tick;

  modport master (
    output vsync, any_button,
    output welcome_grid, logic_grid,
    output added_valid, added_index,
    input  frame_grid, new_tiles, tile_age,
    input  moves_enable, show_welcome,
    input  frame_tick
  );

  modport slave (
    input  vsync, any_button,
    input  welcome_grid, logic_grid,
    input  added_valid, added_index,
    output frame_grid, new_tiles, tile_age,
    output moves_enable, show_welcome,
    output frame_tick
  );

endinterface

// File: rtl/tile_flash_counter.sv
// Per-tile flash down-counter: a load wins over
// a same-cycle decrement, and zero never wraps.
module tile_flash_counter #(
  parameter int CNT_W    = 5,
  parameter int LOAD_VAL = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(LOAD_VAL);
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/grid_frame_controller.sv
// Commits the shown grid once per frame, gates moves
// through WELCOME/ARM/PLAY and tracks tile flash ages.
module grid_frame_controller
  import game_pkg::*;
#(
  parameter int GRID_W       = 4,
  parameter int GRID_H       = 4,
  parameter int TILE_BITS    = 4,
  parameter int FLASH_FRAMES = 25,
  parameter int CNT_W        = 5,
  parameter int AGE_W        = 3
) (
  input logic clk,
  input logic rst_n,
  grid_frame_controller_if.slave bus
);

  localparam int NT = GRID_W * GRID_H;
  localparam int IW = $clog2(NT);

  state_t state_q;
  state_t state_d;

  logic vsync_prev;
  logic vs_edge;
  logic add_ok;

  logic [CNT_W-1:0] cnt [NT];

  assign vs_edge = bus.vsync & ~vsync_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev     <= 1'b0;
      bus.frame_tick <= 1'b0;
    end else begin
      vsync_prev     <= bus.vsync;
      bus.frame_tick <= vs_edge;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WELCOME;
    end else begin
      state_q <= state_d;
    end
  end

  // ARM waits for the start press to be released
  always_comb begin
    state_d = state_q;
    if (vs_edge) begin
      unique case (state_q)
        ST_WELCOME: if (bus.any_button) state_d = ST_ARM;
        ST_ARM:     if (!bus.any_button) state_d = ST_PLAY;
        ST_PLAY:    state_d = ST_PLAY;
        default:    state_d = ST_WELCOME;
      endcase
    end
  end

  always_comb begin
    bus.moves_enable = (state_q == ST_PLAY);
    bus.show_welcome = (state_q == ST_WELCOME)
                     | (state_q == ST_ARM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.frame_grid <= '0;
    end else if (vs_edge) begin
      bus.frame_grid <= (state_q == ST_PLAY)
                      ? bus.logic_grid
                      : bus.welcome_grid;
    end
  end

  assign add_ok = bus.added_valid
                & (state_q == ST_PLAY)
                & (int'(bus.added_index) < NT);

  for (genvar i = 0; i < NT; i++) begin : g_tile
    tile_flash_counter #(
      .CNT_W    (CNT_W),
      .LOAD_VAL (FLASH_FRAMES)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (add_ok && bus.added_index == IW'(i)),
      .dec   (vs_edge),
      .cnt   (cnt[i])
    );

    // age drops the LSB so the phase steps every 2 frames
    assign bus.new_tiles[i] = |cnt[i];
    assign bus.tile_age[i*AGE_W +: AGE_W] =
      cnt[i][AGE_W:1];
  end

endmodule
